// File: rtl/cvp14_pkg.sv
// Shared CVP14 bus definitions: word width, default geometry, FSM and request enums.
package cvp14_pkg;

   localparam int WORD_W         = 16;
   localparam int DEF_ADDR_BITS  = 10;
   localparam int DEF_RD_LATENCY = 2;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_RD   = 2'd1,
      REQ_WR   = 2'd2,
      REQ_BAD  = 2'd3
   } req_t;

   // Reads are always launched (out-of-range reads return zero), so only
   // conflicting strobes and out-of-range writes collapse to REQ_BAD.
   function automatic req_t classify(input logic rd, input logic wr, input logic in_range);
      req_t r;
      r = REQ_NONE;
      if (rd && wr) begin
         r = REQ_BAD;
      end else if (rd) begin
         r = REQ_RD;
      end else if (wr) begin
         r = in_range ? REQ_WR : REQ_BAD;
      end
      return r;
   endfunction

endpackage

// File: rtl/cvp14_mem_responder_if.sv
// CVP14 core <-> memory responder bus. The core is the master.
interface cvp14_mem_responder_if;
   import cvp14_pkg::*;

   logic [WORD_W-1:0] Addr;
   logic              RD;
   logic              WR;
   logic [WORD_W-1:0] DataIn;
   logic [WORD_W-1:0] DataOut;
   logic              DataValid;
   logic              Busy;
   logic              Err;

   modport master (
      output Addr, RD, WR, DataIn,
      input  DataOut, DataValid, Busy, Err
   );

   modport slave (
      input  Addr, RD, WR, DataIn,
      output DataOut, DataValid, Busy, Err
   );

endinterface

// File: rtl/cvp14_rd_pipe.sv
// {valid, data} shift pipeline for read responses. The final stage doubles as
// the output register: it only loads on a valid response, so it holds the
// last returned word between responses.
module cvp14_rd_pipe
   import cvp14_pkg::*;
#(
   parameter int STAGES = DEF_RD_LATENCY,
   parameter int DATA_W = WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data
);

   logic [STAGES-1:0] vld_p;
   logic [DATA_W-1:0] data_p [STAGES];
   logic [STAGES-1:0] vin;
   logic [DATA_W-1:0] din    [STAGES];

   // per-stage inputs: stage 0 from the launch point, others from the stage before
   always_comb begin
      vin = '0;
      din = '{default: '0};
      vin[0] = in_vld;
      din[0] = in_data;
      for (int k = 1; k < STAGES; k++) begin
         vin[k] = vld_p[k-1];
         din[k] = data_p[k-1];
      end
   end

   // valid chain; a flush drops every response still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p <= vin;
      end
   end

   // data chain; only the output stage is cleared, and it loads only on a response
   always_ff @(posedge clk) begin
      for (int k = 0; k < STAGES - 1; k++) begin
         data_p[k] <= din[k];
      end
      if (rst) begin
         data_p[STAGES-1] <= '0;
      end else if (vin[STAGES-1]) begin
         data_p[STAGES-1] <= din[STAGES-1];
      end
   end

   assign out_vld  = vld_p[STAGES-1];
   assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/cvp14_mem_responder.sv
// CVP14 memory responder: word-addressed 16-bit array, zero-fill sweep after
// reset, fixed-latency in-order read responses and an Err strobe for illegal
// requests. Read data is captured from the array on the sampling edge, then
// travels RD_LATENCY further stages to DataOut.
module cvp14_mem_responder
   import cvp14_pkg::*;
#(
   parameter int ADDR_BITS  = DEF_ADDR_BITS,
   parameter int RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic Clk1,
   input  logic Reset,
   cvp14_mem_responder_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_BITS;

   state_t               state_q;
   state_t               state_d;
   logic [ADDR_BITS-1:0] clr_cnt;

   logic [ADDR_BITS-1:0] idx;
   logic                 in_range;
   req_t                 req;

   logic [WORD_W-1:0]    mem [DEPTH];
   logic [WORD_W-1:0]    rd_word;

   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_waddr;
   logic [WORD_W-1:0]    mem_wdata;
   logic                 launch_vld;
   logic [WORD_W-1:0]    launch_data;
   logic                 err_d;
   logic                 err_q;
   logic                 busy;

   logic                 vld_p0;
   logic [WORD_W-1:0]    data_p0;
   logic                 out_vld;
   logic [WORD_W-1:0]    out_data;

   // only the low address bits index the array; any high bit set is out of range
   assign idx      = bus.Addr[ADDR_BITS-1:0];
   assign in_range = (bus.Addr >> ADDR_BITS) == '0;
   assign req      = classify(bus.RD, bus.WR, in_range);
   assign rd_word  = mem[idx];

   // state register and clear counter; reset restarts the sweep at word 0
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state_q <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_BITS'(1);
         end
      end
   end

   // leave CLEAR on the edge that writes the last word
   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (&clr_cnt) state_d = READY;
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   // per-state array write port, read launch and error decode
   always_comb begin
      mem_we      = 1'b0;
      mem_waddr   = idx;
      mem_wdata   = bus.DataIn;
      launch_vld  = 1'b0;
      launch_data = '0;
      err_d       = 1'b0;
      busy        = 1'b0;
      case (state_q)
         CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
            err_d     = bus.RD | bus.WR;
         end
         READY: begin
            case (req)
               REQ_RD: begin
                  launch_vld  = 1'b1;
                  launch_data = in_range ? rd_word : '0;
                  err_d       = ~in_range;
               end
               REQ_WR:  mem_we = 1'b1;
               REQ_BAD: err_d  = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // storage array; writes are suppressed on reset edges
   always_ff @(posedge Clk1) begin
      if (mem_we && !Reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // launch stage: array word captured on the sampling edge, so later writes cannot alter it
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= launch_vld;
      end
      data_p0 <= launch_data;
   end

   // Err is a registered one-cycle strobe
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   cvp14_rd_pipe #(
      .STAGES (RD_LATENCY),
      .DATA_W (WORD_W)
   ) u_rd_pipe (
      .clk      (Clk1),
      .rst      (Reset),
      .in_vld   (vld_p0),
      .in_data  (data_p0),
      .out_vld  (out_vld),
      .out_data (out_data)
   );

   assign bus.DataOut   = out_data;
   assign bus.DataValid = out_vld;
   assign bus.Busy      = busy;
   assign bus.Err       = err_q;

endmodule
